rob_retire_unit: RTL and testbench
==================================

Name: rob_retire_unit

Overview:
In-order reorder buffer that sits on the far side of the rename stage. Rename pushes each dispatched instruction with its new destination preg and the old preg it displaced. Functional units report completion by ROB index. The block retires completed entries in program order, up to RETIRE_W per cycle. For each retired entry it returns the displaced old preg to the rename free pool as a one-hot free mask.

Parameters:
ROB_DEPTH, 16, number of entries (power of 2, >=4)
NUM_PREG, 64, physical register count; width of the free mask
PREG_W, 6, physical register index width (log2 NUM_PREG)
RETIRE_W, 2, max retirements per cycle (fixed at 2 in this version)
NUM_CMPL, 3, completion ports (ALU, MUL, LSU)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  synchronous active-low reset
alloc_valid  in  1  rename presents one instruction this cycle
alloc_ready  out  1  entry available (= !rob_full)
alloc_has_dest  in  1  instruction writes a register (0 for store/NOP)
alloc_areg  in  5  architectural destination
alloc_preg  in  PREG_W  new physical destination
alloc_old_preg  in  PREG_W  preg previously mapped to alloc_areg
alloc_rob_idx  out  log2(ROB_DEPTH)  index assigned to the presented instruction (= tail)
cmpl_valid  in  NUM_CMPL  per-port completion strobe
cmpl_rob_idx  in  NUM_CMPL*log2(ROB_DEPTH)  packed completion indices, port 0 in LSBs
retire_free_mask  out  NUM_PREG  registered one-hot-per-preg pulse of old pregs to free
retire_count  out  2  registered number of entries retired in the last cycle (0..2)
rob_empty  out  1  count == 0
rob_full  out  1  count == ROB_DEPTH

Behaviour:
- Reset is rstn, synchronous, active-low; clock is clk. On reset: all entry valid/done bits = 0, head = tail = 0 (wrap bits 0), count = 0, retire_free_mask = 0, retire_count = 0. Outputs after reset: rob_empty = 1, rob_full = 0, alloc_ready = 1, alloc_rob_idx = 0. Reset mid-operation discards all in-flight entries; no free mask is emitted for them.
- Storage: circular buffer. Each entry holds valid, done, has_dest, areg, preg, old_preg. Head and tail pointers carry an extra wrap bit; count is derived from the pointer difference.
- Allocate: alloc_valid && alloc_ready at an edge writes the entry at tail (valid=1, done=0) and tail increments mod ROB_DEPTH. alloc_rob_idx is combinational from tail.
  - rob_full is computed from pre-edge state only. A same-cycle retirement does not free room for a same-cycle allocate (no bypass).
- Complete: each cmpl_valid[k] sets done of entry cmpl_rob_idx[k] at the edge, but only if that entry is valid. Completion to an invalid entry is ignored.
  - Duplicate indices on several ports in one cycle are legal and behave as one completion.
  - A completion never sets done on an entry being allocated in the same cycle. The allocation result wins.
- Retire, evaluated on pre-edge state:
  - slot0 = entry[head] valid && done.
  - slot1 = slot0 && entry[head+1] valid && done.
  - Retired entries are cleared (valid=0) and head advances by the number retired.
  - A completion arriving in cycle N is retirable at the earliest in cycle N+1. There is no completion-to-retire bypass.
- Free mask, registered, one-cycle pulse:
  - retire_free_mask = OR of one-hot(old_preg) over retired entries with has_dest=1 and old_preg != 0.
  - All bits return to 0 the next cycle unless new retirements occur.
  - Preg 0 is never freed.
  - If two retirements name the same old_preg (illegal from rename), the bit is simply set once.
- retire_count is registered alongside retire_free_mask.
- Simultaneous alloc + retire when not full: count = count + 1 − retired. Wrap-around of head and tail at ROB_DEPTH−1 → 0 flips the wrap bit. Full/empty are distinguished by the wrap bit.

Decomposition:
- Shared package rob_pkg holds:
  - constants ROB_DEPTH, ROB_IDX_W, PREG_W, NUM_PREG;
  - typedef rob_entry_t {valid, done, has_dest, areg[4:0], preg, old_preg};
  - typedef rob_ptr_t {wrap, idx}.
- One sub-module is natural: rob_retire_sel. It is combinational; it takes head, the entry array and the valid/done bits, and produces the retire enables for slot0/slot1 and the next free mask.

Test Plan:
- Reset then idle → rob_empty=1, alloc_rob_idx=0, retire_free_mask=0 for 5 cycles.
- Alloc 3 entries (old_preg 5, 6, 7; has_dest=1), complete idx 1 then idx 0 in the next cycle → one cycle later retire_count=2, mask bits 5 and 6 set; idx 2 stays pending.
- Fill 16 entries → rob_full=1 and alloc_ready=0. Complete idx 0 and retire; an alloc_valid in the same retire cycle is not accepted; the next cycle it is accepted at idx 0 with the wrap bit flipped.
- Store (has_dest=0, old_preg=9) and an entry with old_preg=0, both completed → both retire, retire_free_mask=0, retire_count=2.
- Complete idx 4 on ports 0 and 2 simultaneously, plus a completion to an invalid idx 12 → only entry 4 is marked done; entry 12 stays invalid.
- Assert rstn=0 with 8 entries in flight, 3 done → next cycle count=0, mask=0, and no subsequent retirement occurs.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer retire slice.
package rob_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_IDX_W = 4;
   localparam int NUM_PREG  = 64;
   localparam int PREG_W    = 6;
   localparam int AREG_W    = 5;
   localparam int RETIRE_W  = 2;
   localparam int NUM_CMPL  = 3;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_dest;
      logic [AREG_W-1:0] areg;
      logic [PREG_W-1:0] preg;
      logic [PREG_W-1:0] old_preg;
   } rob_entry_t;

   // Pointer with an extra wrap bit so full and empty can be told apart.
   typedef struct packed {
      logic                 wrap;
      logic [ROB_IDX_W-1:0] idx;
   } rob_ptr_t;

   // One-hot free request for a retiring entry; preg 0 is never returned.
   function automatic logic [NUM_PREG-1:0] free_onehot(input logic          has_dest,
                                                       input logic [PREG_W-1:0] old_preg);
      logic [NUM_PREG-1:0] m;
      m = '0;
      if (has_dest && (old_preg != '0)) m[old_preg] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Combinational retire selection: decides how many entries leave the head
// this cycle and which old pregs they hand back to the free pool.
module rob_retire_sel
   import rob_pkg::*;
(
   input  logic [ROB_IDX_W-1:0] head_idx,
   input  rob_entry_t           entries [ROB_DEPTH],
   output logic                 retire0,
   output logic                 retire1,
   output logic [ROB_IDX_W-1:0] slot1_idx,
   output logic [1:0]           retire_num,
   output logic [NUM_PREG-1:0]  free_mask
);

   // Slot1 may only retire behind slot0 so program order is preserved.
   always_comb begin
      slot1_idx  = head_idx + ROB_IDX_W'(1);
      retire0    = entries[head_idx].valid && entries[head_idx].done;
      retire1    = retire0 && entries[slot1_idx].valid && entries[slot1_idx].done;
      retire_num = {retire1, retire0 & ~retire1};
      free_mask  = '0;
      if (retire0)
         free_mask = free_mask | free_onehot(entries[head_idx].has_dest,
                                             entries[head_idx].old_preg);
      if (retire1)
         free_mask = free_mask | free_onehot(entries[slot1_idx].has_dest,
                                             entries[slot1_idx].old_preg);
   end

endmodule

// File: rtl/rob_retire_unit.sv
// In-order reorder buffer: allocates at tail, marks completions by index,
// retires up to two completed entries per cycle from head and pulses the
// displaced pregs back to rename as a one-hot free mask.
//
// Allocation handshake: an instruction transfers on a rising edge where
// alloc_valid && alloc_ready; alloc_ready depends only on registered state
// (not full), so a retirement in the same cycle never makes room early.
module rob_retire_unit
   import rob_pkg::*;
(
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            alloc_valid,
   output logic                            alloc_ready,
   input  logic                            alloc_has_dest,
   input  logic [4:0]                      alloc_areg,
   input  logic [PREG_W-1:0]               alloc_preg,
   input  logic [PREG_W-1:0]               alloc_old_preg,
   output logic [ROB_IDX_W-1:0]            alloc_rob_idx,
   input  logic [NUM_CMPL-1:0]             cmpl_valid,
   input  logic [NUM_CMPL*ROB_IDX_W-1:0]   cmpl_rob_idx,
   output logic [NUM_PREG-1:0]             retire_free_mask,
   output logic [1:0]                      retire_count,
   output logic                            rob_empty,
   output logic                            rob_full
);

   rob_entry_t           rob_q [ROB_DEPTH];
   rob_entry_t           rob_d [ROB_DEPTH];
   rob_ptr_t             head_q;
   rob_ptr_t             tail_q;
   logic [ROB_IDX_W:0]   head_sum;
   logic [ROB_IDX_W:0]   tail_sum;
   logic                 alloc_fire;
   logic [ROB_DEPTH-1:0] cmpl_hit;
   logic                 retire0;
   logic                 retire1;
   logic [ROB_IDX_W-1:0] slot1_idx;
   logic [1:0]           retire_num;
   logic [NUM_PREG-1:0]  free_mask_d;
   logic [NUM_PREG-1:0]  free_mask_q;
   logic [1:0]           retire_count_q;

   // Status and allocation handshake from registered pointers only.
   always_comb begin
      rob_empty     = (head_q == tail_q);
      rob_full      = (head_q.idx == tail_q.idx) && (head_q.wrap != tail_q.wrap);
      alloc_ready   = !rob_full;
      alloc_fire    = alloc_valid && !rob_full;
      alloc_rob_idx = tail_q.idx;
   end

   // Fold all completion ports into a per-entry hit vector; duplicates merge.
   always_comb begin
      cmpl_hit = '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
         for (int k = 0; k < NUM_CMPL; k++) begin
            if (cmpl_valid[k] &&
                (cmpl_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] == ROB_IDX_W'(i)))
               cmpl_hit[i] = 1'b1;
         end
      end
   end

   rob_retire_sel u_sel (
      .head_idx   (head_q.idx),
      .entries    (rob_q),
      .retire0    (retire0),
      .retire1    (retire1),
      .slot1_idx  (slot1_idx),
      .retire_num (retire_num),
      .free_mask  (free_mask_d)
   );

   // Next entry state: completion, then retire clear, then allocation wins.
   always_comb begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
         rob_d[i] = rob_q[i];
         if (cmpl_hit[i] && rob_q[i].valid)
            rob_d[i].done = 1'b1;
         if ((retire0 && (head_q.idx == ROB_IDX_W'(i))) ||
             (retire1 && (slot1_idx == ROB_IDX_W'(i)))) begin
            rob_d[i].valid = 1'b0;
            rob_d[i].done  = 1'b0;
         end
         if (alloc_fire && (tail_q.idx == ROB_IDX_W'(i))) begin
            rob_d[i].valid    = 1'b1;
            rob_d[i].done     = 1'b0;
            rob_d[i].has_dest = alloc_has_dest;
            rob_d[i].areg     = alloc_areg;
            rob_d[i].preg     = alloc_preg;
            rob_d[i].old_preg = alloc_old_preg;
         end
      end
   end

   // Pointer advance; the wrap bit flips naturally on carry out of idx.
   always_comb begin
      head_sum = {head_q.wrap, head_q.idx} + {{(ROB_IDX_W-1){1'b0}}, retire_num};
      tail_sum = {tail_q.wrap, tail_q.idx} + {{ROB_IDX_W{1'b0}}, alloc_fire};
   end

   // State registers; reset drops all in-flight entries without freeing them.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q         <= '0;
         tail_q         <= '0;
         free_mask_q    <= '0;
         retire_count_q <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      end else begin
         head_q         <= rob_ptr_t'(head_sum);
         tail_q         <= rob_ptr_t'(tail_sum);
         free_mask_q    <= free_mask_d;
         retire_count_q <= retire_num;
         for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= rob_d[i];
      end
   end

   // Registered retire outputs, one-cycle pulses.
   always_comb begin
      retire_free_mask = free_mask_q;
      retire_count     = retire_count_q;
   end

endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed bench for rob_retire_unit with a scoreboard on retire events.
module tb_rob_retire_unit;

   logic        clk;
   logic        rstn;
   logic        alloc_valid;
   logic        alloc_ready;
   logic        alloc_has_dest;
   logic [4:0]  alloc_areg;
   logic [5:0]  alloc_preg;
   logic [5:0]  alloc_old_preg;
   logic [3:0]  alloc_rob_idx;
   logic [2:0]  cmpl_valid;
   logic [11:0] cmpl_rob_idx;
   logic [63:0] retire_free_mask;
   logic [1:0]  retire_count;
   logic        rob_empty;
   logic        rob_full;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 0;
   logic [65:0] exp_q[$];
   logic [65:0] mon_exp;

   rob_retire_unit dut (
      .clk              (clk),
      .rstn             (rstn),
      .alloc_valid      (alloc_valid),
      .alloc_ready      (alloc_ready),
      .alloc_has_dest   (alloc_has_dest),
      .alloc_areg       (alloc_areg),
      .alloc_preg       (alloc_preg),
      .alloc_old_preg   (alloc_old_preg),
      .alloc_rob_idx    (alloc_rob_idx),
      .cmpl_valid       (cmpl_valid),
      .cmpl_rob_idx     (cmpl_rob_idx),
      .retire_free_mask (retire_free_mask),
      .retire_count     (retire_count),
      .rob_empty        (rob_empty),
      .rob_full         (rob_full)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected retire event: count in the top bits, free mask below.
   function automatic logic [65:0] mk(input logic [1:0] n, input int a, input int b);
      logic [63:0] m;
      m = '0;
      if (a > 0) m[a] = 1'b1;
      if (b > 0) m[b] = 1'b1;
      return {n, m};
   endfunction

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   task automatic alloc(input logic hd, input logic [5:0] old, input logic [3:0] exp_idx);
      alloc_valid    = 1'b1;
      alloc_has_dest = hd;
      alloc_areg     = 5'($urandom_range(1, 31));
      alloc_preg     = 6'($urandom_range(1, 63));
      alloc_old_preg = old;
      chk("alloc_ready", alloc_ready, 1'b1);
      chk("alloc_rob_idx", alloc_rob_idx, exp_idx);
      step();
      alloc_valid = 1'b0;
   endtask

   task automatic cmpl(input logic [2:0] v, input logic [3:0] i0, input logic [3:0] i1,
                       input logic [3:0] i2);
      cmpl_valid   = v;
      cmpl_rob_idx = {i2, i1, i0};
      step();
      cmpl_valid = 3'b000;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Scoreboard monitor: every retire pulse must match the next expected entry.
   always @(negedge clk) begin
      if (mon_en && ((retire_count !== 2'd0) || (retire_free_mask !== 64'd0))) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_retire", {retire_count, retire_free_mask}, 66'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("retire", {retire_count, retire_free_mask}, mon_exp);
         end
      end
   end

   initial begin
      rstn = 1'b0; alloc_valid = 1'b0; alloc_has_dest = 1'b0; alloc_areg = '0;
      alloc_preg = '0; alloc_old_preg = '0; cmpl_valid = '0; cmpl_rob_idx = '0;
      step();
      step();
      mon_en = 1'b1;
      rstn   = 1'b1;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         chk("idle_empty", rob_empty, 1'b1);
         chk("idle_idx", alloc_rob_idx, 4'd0);
         chk("idle_mask", retire_free_mask, 64'd0);
         step();
      end
      chk("idle_full", rob_full, 1'b0);

      // Three allocs, out-of-order completion, in-order pair retire
      alloc(1'b1, 6'd5, 4'd0);
      alloc(1'b1, 6'd6, 4'd1);
      alloc(1'b1, 6'd7, 4'd2);
      cmpl(3'b001, 4'd1, 4'd0, 4'd0);
      exp_q.push_back(mk(2'd2, 5, 6));
      cmpl(3'b001, 4'd0, 4'd0, 4'd0);
      idle(3);
      chk("pending_not_empty", rob_empty, 1'b0);
      exp_q.push_back(mk(2'd1, 7, 0));
      cmpl(3'b010, 4'd0, 4'd2, 4'd0);
      idle(3);
      chk("drained_empty", rob_empty, 1'b1);

      // Fill to full, retire one, no same-cycle alloc bypass, wrap to idx 0
      do_reset();
      for (int i = 0; i < 16; i++) alloc(1'b1, 6'(16 + i), 4'(i));
      chk("full", rob_full, 1'b1);
      chk("full_ready", alloc_ready, 1'b0);
      chk("full_idx", alloc_rob_idx, 4'd0);
      exp_q.push_back(mk(2'd1, 16, 0));
      cmpl(3'b001, 4'd0, 4'd0, 4'd0);
      alloc_valid = 1'b1; alloc_has_dest = 1'b1; alloc_old_preg = 6'd45;
      chk("retire_cycle_ready", alloc_ready, 1'b0);
      step();
      alloc_valid = 1'b0;
      alloc(1'b1, 6'd40, 4'd0);
      chk("full_again", rob_full, 1'b1);

      // Drain across the wrap point, two per cycle
      for (int j = 0; j < 7; j++) exp_q.push_back(mk(2'd2, 17 + 2*j, 18 + 2*j));
      exp_q.push_back(mk(2'd2, 31, 40));
      cmpl(3'b111, 4'd1, 4'd2, 4'd3);
      cmpl(3'b111, 4'd4, 4'd5, 4'd6);
      cmpl(3'b111, 4'd7, 4'd8, 4'd9);
      cmpl(3'b111, 4'd10, 4'd11, 4'd12);
      cmpl(3'b111, 4'd13, 4'd14, 4'd15);
      cmpl(3'b001, 4'd0, 4'd0, 4'd0);
      idle(5);
      chk("wrap_drain_empty", rob_empty, 1'b1);

      // Store and preg-0 entry retire with an empty mask
      alloc(1'b0, 6'd9, 4'd1);
      alloc(1'b1, 6'd0, 4'd2);
      exp_q.push_back(mk(2'd2, 0, 0));
      cmpl(3'b011, 4'd1, 4'd2, 4'd0);
      idle(3);
      chk("store_empty", rob_empty, 1'b1);

      // Duplicate completion ports and completion to an invalid entry
      do_reset();
      for (int i = 0; i < 5; i++) alloc(1'b1, 6'(50 + i), 4'(i));
      cmpl(3'b111, 4'd4, 4'd12, 4'd4);
      idle(3);
      exp_q.push_back(mk(2'd2, 50, 51));
      exp_q.push_back(mk(2'd2, 52, 53));
      exp_q.push_back(mk(2'd1, 54, 0));
      cmpl(3'b111, 4'd0, 4'd1, 4'd2);
      cmpl(3'b001, 4'd3, 4'd0, 4'd0);
      idle(4);
      chk("dup_empty", rob_empty, 1'b1);

      // Reset with eight in flight, three of them done
      for (int i = 0; i < 8; i++) alloc(1'b1, 6'(1 + i), 4'(5 + i));
      cmpl(3'b111, 4'd6, 4'd7, 4'd8);
      rstn = 1'b0;
      step();
      chk("rst_empty", rob_empty, 1'b1);
      chk("rst_full", rob_full, 1'b0);
      chk("rst_idx", alloc_rob_idx, 4'd0);
      chk("rst_count", retire_count, 2'd0);
      chk("rst_mask", retire_free_mask, 64'd0);
      rstn = 1'b1;
      cmpl(3'b111, 4'd0, 4'd1, 4'd2);
      cmpl(3'b111, 4'd5, 4'd6, 4'd7);
      idle(5);
      chk("post_rst_empty", rob_empty, 1'b1);
      chk("exp_q_drained", 66'(exp_q.size()), 66'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
